// File: rtl/dlx_pkg.sv
// DLX decode constants: opcodes, R-type and FP function codes,
// ALU/FPU control encodings and the decoded control bundle.
package dlx_pkg;

    // Primary opcodes, instruction bits [0:5]
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_FPARITH = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDUI   = 6'h09;
    localparam logic [5:0] OP_SUBI    = 6'h0A;
    localparam logic [5:0] OP_SUBUI   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LHI     = 6'h0F;
    localparam logic [5:0] OP_JR      = 6'h12;
    localparam logic [5:0] OP_JALR    = 6'h13;
    localparam logic [5:0] OP_SLLI    = 6'h14;
    localparam logic [5:0] OP_SRLI    = 6'h16;
    localparam logic [5:0] OP_SRAI    = 6'h17;
    localparam logic [5:0] OP_SEQI    = 6'h18;
    localparam logic [5:0] OP_SNEI    = 6'h19;
    localparam logic [5:0] OP_SLTI    = 6'h1A;
    localparam logic [5:0] OP_SGTI    = 6'h1B;
    localparam logic [5:0] OP_SLEI    = 6'h1C;
    localparam logic [5:0] OP_SGEI    = 6'h1D;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // R-type function codes (op 0x00), bits [26:31]
    localparam logic [5:0] FN_SLL     = 6'h04;
    localparam logic [5:0] FN_SRL     = 6'h06;
    localparam logic [5:0] FN_SRA     = 6'h07;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_SEQ     = 6'h28;
    localparam logic [5:0] FN_SNE     = 6'h29;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SGT     = 6'h2B;
    localparam logic [5:0] FN_SLE     = 6'h2C;
    localparam logic [5:0] FN_SGE     = 6'h2D;
    localparam logic [5:0] FN_MOVFP2I = 6'h34;
    localparam logic [5:0] FN_MOVI2FP = 6'h35;

    // FP R-type function codes (op 0x01)
    localparam logic [5:0] FF_ADDF    = 6'h00;
    localparam logic [5:0] FF_SUBF    = 6'h01;
    localparam logic [5:0] FF_MULTF   = 6'h02;
    localparam logic [5:0] FF_DIVF    = 6'h03;
    localparam logic [5:0] FF_MULT    = 6'h0E;
    localparam logic [5:0] FF_MULTU   = 6'h16;

    localparam logic [4:0] LINK_REG   = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SEQ    = 4'd8,
        ALU_SNE    = 4'd9,
        ALU_SLT    = 4'd10,
        ALU_SGT    = 4'd11,
        ALU_SLE    = 4'd12,
        ALU_SGE    = 4'd13,
        ALU_LHI    = 4'd14,
        ALU_PASS_A = 4'd15
    } alu_op_e;

    typedef enum logic [3:0] {
        FPU_MULT   = 4'd0,
        FPU_MULTU  = 4'd1,
        FPU_ADDF   = 4'd2,
        FPU_SUBF   = 4'd3,
        FPU_MULTF  = 4'd4,
        FPU_DIVF   = 4'd5
    } fpu_op_e;

    // Which instruction field names the write-back register
    typedef enum logic [1:0] {
        RD_I    = 2'd0,
        RD_R    = 2'd1,
        RD_LINK = 2'd2
    } rd_sel_e;

    typedef struct packed {
        logic    branch;
        logic    jump;
        logic    jump_use_reg;
        logic    jal;
        logic    mem_wr;
        logic    mem_to_reg;
        logic    mem_byte;
        logic    mem_half;
        logic    mem_sext;
        logic    mov;
        logic    zext_imm;
        logic    b_from_reg;
        logic    gp_we;
        logic    fp_we;
        rd_sel_e rd_sel;
        alu_op_e alu;
        fpu_op_e fpu;
    } ctrl_t;

    function automatic logic [31:0] ext_imm16(
        input logic [15:0] imm,
        input logic        zext
    );
        return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/regfile32x32.sv
// 32x32 register file: two combinational read ports, one write port
// on the rising edge, asynchronous active-low clear of all entries.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i (write),
//   raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o (reads).
// ZeroR0 = 1 hardwires entry 0 to zero (GP file).
module regfile32x32 #(
    parameter bit ZeroR0 = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [32];
    logic        wr_en;
    logic        zero_a;
    logic        zero_b;

    assign wr_en  = we_i && !(ZeroR0 && (waddr_i == 5'd0));
    assign zero_a = ZeroR0 && (raddr_a_i == 5'd0);
    assign zero_b = ZeroR0 && (raddr_b_i == 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the stored value; a same-cycle write lands at the edge
    assign rdata_a_o = zero_a ? 32'h0 : regs_q[raddr_a_i];
    assign rdata_b_o = zero_b ? 32'h0 : regs_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// DLX instruction decode: control decode plus GP and FP register files.
// Ports: clk, reset (async active-low), instruction, BUS_W/FBUS_W
//   (write-back data); outputs GP/FP operands, STORE_DATA and controls.
module id_stage
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] BUS_W,
    input  logic [31:0] FBUS_W,
    output logic [31:0] OPERAND_A,
    output logic [31:0] OPERAND_B,
    output logic [31:0] STORE_DATA,
    output logic [31:0] F_OPERAND_A,
    output logic [31:0] F_OPERAND_B,
    output logic        BRANCH,
    output logic        JUMP,
    output logic        JUMP_USE_REG,
    output logic        JAL_INSTR,
    output logic [3:0]  ALU_CTRL_BITS,
    output logic [3:0]  FPU_CTRL_BITS,
    output logic        MEM_WR,
    output logic        MEM_TO_REG,
    output logic        MEM_BYTE_OP,
    output logic        MEM_HALFWORD_OP,
    output logic        MEM_SIGN_EXT,
    output logic        MOV_INSTR
);

    // Big-endian field positions mapped onto [31:0] numbering
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd_r;
    logic [5:0]  func;
    logic [15:0] imm16;

    assign op    = instruction[31:26];
    assign rs1   = instruction[25:21];
    assign rs2   = instruction[20:16];
    assign rd_r  = instruction[15:11];
    assign func  = instruction[5:0];
    assign imm16 = instruction[15:0];

    ctrl_t       ctrl;
    logic [4:0]  waddr;
    logic [31:0] imm_ext;
    logic [31:0] gp_a;
    logic [31:0] gp_b;

    always_comb begin
        ctrl = '0;
        unique case (op)
            OP_SPECIAL: begin
                ctrl.b_from_reg = 1'b1;
                ctrl.rd_sel     = RD_R;
                ctrl.gp_we      = 1'b1;
                unique case (func)
                    FN_ADD, FN_ADDU: ctrl.alu = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu = ALU_SUB;
                    FN_AND:          ctrl.alu = ALU_AND;
                    FN_OR:           ctrl.alu = ALU_OR;
                    FN_XOR:          ctrl.alu = ALU_XOR;
                    FN_SLL:          ctrl.alu = ALU_SLL;
                    FN_SRL:          ctrl.alu = ALU_SRL;
                    FN_SRA:          ctrl.alu = ALU_SRA;
                    FN_SEQ:          ctrl.alu = ALU_SEQ;
                    FN_SNE:          ctrl.alu = ALU_SNE;
                    FN_SLT:          ctrl.alu = ALU_SLT;
                    FN_SGT:          ctrl.alu = ALU_SGT;
                    FN_SLE:          ctrl.alu = ALU_SLE;
                    FN_SGE:          ctrl.alu = ALU_SGE;
                    FN_MOVFP2I: begin
                        ctrl.mov = 1'b1;
                        ctrl.alu = ALU_PASS_A;
                    end
                    FN_MOVI2FP: begin
                        ctrl.mov   = 1'b1;
                        ctrl.alu   = ALU_PASS_A;
                        ctrl.gp_we = 1'b0;
                        ctrl.fp_we = 1'b1;
                    end
                    // includes the all-zero NOP
                    default: ctrl.gp_we = 1'b0;
                endcase
            end
            OP_FPARITH: begin
                ctrl.b_from_reg = 1'b1;
                ctrl.rd_sel     = RD_R;
                ctrl.fp_we      = 1'b1;
                unique case (func)
                    FF_ADDF:  ctrl.fpu = FPU_ADDF;
                    FF_SUBF:  ctrl.fpu = FPU_SUBF;
                    FF_MULTF: ctrl.fpu = FPU_MULTF;
                    FF_DIVF:  ctrl.fpu = FPU_DIVF;
                    FF_MULT:  ctrl.fpu = FPU_MULT;
                    FF_MULTU: ctrl.fpu = FPU_MULTU;
                    default:  ctrl.fp_we = 1'b0;
                endcase
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump   = 1'b1;
                ctrl.jal    = 1'b1;
                ctrl.gp_we  = 1'b1;
                ctrl.rd_sel = RD_LINK;
            end
            OP_JR: begin
                ctrl.jump         = 1'b1;
                ctrl.jump_use_reg = 1'b1;
            end
            OP_JALR: begin
                ctrl.jump         = 1'b1;
                ctrl.jump_use_reg = 1'b1;
                ctrl.jal          = 1'b1;
                ctrl.gp_we        = 1'b1;
                ctrl.rd_sel       = RD_LINK;
            end
            OP_BEQZ: begin
                ctrl.branch = 1'b1;
                ctrl.alu    = ALU_SEQ;
            end
            OP_BNEZ: begin
                ctrl.branch = 1'b1;
                ctrl.alu    = ALU_SNE;
            end
            OP_ADDI: begin
                ctrl.gp_we = 1'b1;
            end
            OP_ADDUI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
            end
            OP_SUBI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_SUB;
            end
            OP_SUBUI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
                ctrl.alu      = ALU_SUB;
            end
            OP_ANDI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
                ctrl.alu      = ALU_AND;
            end
            OP_ORI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
                ctrl.alu      = ALU_OR;
            end
            OP_XORI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
                ctrl.alu      = ALU_XOR;
            end
            // imm16 passes through; the ALU does the shift by 16
            OP_LHI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_LHI;
            end
            OP_SLLI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
                ctrl.alu      = ALU_SLL;
            end
            OP_SRLI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
                ctrl.alu      = ALU_SRL;
            end
            OP_SRAI: begin
                ctrl.gp_we    = 1'b1;
                ctrl.zext_imm = 1'b1;
                ctrl.alu      = ALU_SRA;
            end
            OP_SEQI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_SEQ;
            end
            OP_SNEI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_SNE;
            end
            OP_SLTI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_SLT;
            end
            OP_SGTI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_SGT;
            end
            OP_SLEI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_SLE;
            end
            OP_SGEI: begin
                ctrl.gp_we = 1'b1;
                ctrl.alu   = ALU_SGE;
            end
            OP_LB: begin
                ctrl.gp_we      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_byte   = 1'b1;
                ctrl.mem_sext   = 1'b1;
            end
            OP_LBU: begin
                ctrl.gp_we      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_byte   = 1'b1;
            end
            OP_LH: begin
                ctrl.gp_we      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_half   = 1'b1;
                ctrl.mem_sext   = 1'b1;
            end
            OP_LHU: begin
                ctrl.gp_we      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_half   = 1'b1;
            end
            OP_LW: begin
                ctrl.gp_we      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.mem_wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign waddr = (ctrl.rd_sel == RD_LINK) ? LINK_REG :
                   (ctrl.rd_sel == RD_R)    ? rd_r     :
                                              rs2;

    assign imm_ext = ext_imm16(imm16, ctrl.zext_imm);

    regfile32x32 #(
        .ZeroR0 (1'b1)
    ) u_gp_rf (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (ctrl.gp_we),
        .waddr_i   (waddr),
        .wdata_i   (BUS_W),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (gp_a),
        .rdata_b_o (gp_b)
    );

    regfile32x32 #(
        .ZeroR0 (1'b0)
    ) u_fp_rf (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (ctrl.fp_we),
        .waddr_i   (waddr),
        .wdata_i   (FBUS_W),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (F_OPERAND_A),
        .rdata_b_o (F_OPERAND_B)
    );

    assign OPERAND_A       = gp_a;
    assign OPERAND_B       = ctrl.b_from_reg ? gp_b : imm_ext;
    // Stores name their data register in the rs2 field
    assign STORE_DATA      = gp_b;

    assign BRANCH          = ctrl.branch;
    assign JUMP            = ctrl.jump;
    assign JUMP_USE_REG    = ctrl.jump_use_reg;
    assign JAL_INSTR       = ctrl.jal;
    assign ALU_CTRL_BITS   = ctrl.alu;
    assign FPU_CTRL_BITS   = ctrl.fpu;
    assign MEM_WR          = ctrl.mem_wr;
    assign MEM_TO_REG      = ctrl.mem_to_reg;
    assign MEM_BYTE_OP     = ctrl.mem_byte;
    assign MEM_HALFWORD_OP = ctrl.mem_half;
    assign MEM_SIGN_EXT    = ctrl.mem_sext;
    assign MOV_INSTR       = ctrl.mov;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table with a reference register model,
// expected outputs queued at drive time and compared when sampled.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] BUS_W = 32'h0;
    logic [31:0] FBUS_W = 32'h0;
    logic [31:0] OPERAND_A, OPERAND_B, STORE_DATA;
    logic [31:0] F_OPERAND_A, F_OPERAND_B;
    logic        BRANCH, JUMP, JUMP_USE_REG, JAL_INSTR;
    logic [3:0]  ALU_CTRL_BITS, FPU_CTRL_BITS;
    logic        MEM_WR, MEM_TO_REG, MEM_BYTE_OP;
    logic        MEM_HALFWORD_OP, MEM_SIGN_EXT, MOV_INSTR;

    always #5 clk = ~clk;

    id_stage dut (
        .clk             (clk),
        .reset           (reset),
        .instruction     (instruction),
        .BUS_W           (BUS_W),
        .FBUS_W          (FBUS_W),
        .OPERAND_A       (OPERAND_A),
        .OPERAND_B       (OPERAND_B),
        .STORE_DATA      (STORE_DATA),
        .F_OPERAND_A     (F_OPERAND_A),
        .F_OPERAND_B     (F_OPERAND_B),
        .BRANCH          (BRANCH),
        .JUMP            (JUMP),
        .JUMP_USE_REG    (JUMP_USE_REG),
        .JAL_INSTR       (JAL_INSTR),
        .ALU_CTRL_BITS   (ALU_CTRL_BITS),
        .FPU_CTRL_BITS   (FPU_CTRL_BITS),
        .MEM_WR          (MEM_WR),
        .MEM_TO_REG      (MEM_TO_REG),
        .MEM_BYTE_OP     (MEM_BYTE_OP),
        .MEM_HALFWORD_OP (MEM_HALFWORD_OP),
        .MEM_SIGN_EXT    (MEM_SIGN_EXT),
        .MOV_INSTR       (MOV_INSTR)
    );

    // {BR,J,JR,JAL,MW,M2R,BYTE,HALF,SEXT,MOV}
    localparam logic [9:0] F_NONE = 10'b0000000000;
    localparam logic [9:0] F_BR   = 10'b1000000000;
    localparam logic [9:0] F_J    = 10'b0100000000;
    localparam logic [9:0] F_JR   = 10'b0010000000;
    localparam logic [9:0] F_JAL  = 10'b0001000000;
    localparam logic [9:0] F_MW   = 10'b0000100000;
    localparam logic [9:0] F_M2R  = 10'b0000010000;
    localparam logic [9:0] F_B    = 10'b0000001000;
    localparam logic [9:0] F_H    = 10'b0000000100;
    localparam logic [9:0] F_SE   = 10'b0000000010;
    localparam logic [9:0] F_MOV  = 10'b0000000001;

    logic [17:0] dut_ctl;
    assign dut_ctl = {BRANCH, JUMP, JUMP_USE_REG, JAL_INSTR,
                      MEM_WR, MEM_TO_REG, MEM_BYTE_OP,
                      MEM_HALFWORD_OP, MEM_SIGN_EXT, MOV_INSTR,
                      ALU_CTRL_BITS, FPU_CTRL_BITS};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] busw;
        logic [31:0] fbusw;
        logic [17:0] ctl;
        logic        bimm;
        logic [31:0] imm;
        logic        gw;
        logic        fw;
        logic [4:0]  dst;
    } vec_t;

    typedef struct {
        logic [17:0] ctl;
        logic [31:0] a, b, sd, fa, fb;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    logic [31:0] gp [32];
    logic [31:0] fp [32];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] it(input logic [5:0] op,
        input logic [4:0] rs1, input logic [4:0] rd,
        input logic [15:0] imm);
        return {op, rs1, rd, imm};
    endfunction

    function automatic logic [31:0] rt(input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] rd,
        input logic [5:0] fn);
        return {6'h00, rs1, rs2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] ft(input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] rd,
        input logic [5:0] fn);
        return {6'h01, rs1, rs2, rd, 5'd0, fn};
    endfunction

    function automatic logic [17:0] cw(input logic [9:0] f,
        input logic [3:0] alu, input logic [3:0] fpu);
        return {f, alu, fpu};
    endfunction

    function automatic vec_t v(input logic [31:0] instr,
        input logic [31:0] busw, input logic [31:0] fbusw,
        input logic [17:0] ctl, input logic bimm,
        input logic [31:0] imm, input logic gw,
        input logic fw, input logic [4:0] dst);
        vec_t r;
        r.instr = instr; r.busw = busw; r.fbusw = fbusw;
        r.ctl = ctl; r.bimm = bimm; r.imm = imm;
        r.gw = gw; r.fw = fw; r.dst = dst;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
        input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t r,
        input logic rst_val);
        exp_t e;
        exp_t g;
        logic [4:0] s1;
        logic [4:0] s2;
        @(negedge clk);
        reset = rst_val;
        instruction = r.instr;
        BUS_W = r.busw;
        FBUS_W = r.fbusw;
        if (!rst_val) begin
            for (int i = 0; i < 32; i++) begin
                gp[i] = 32'h0;
                fp[i] = 32'h0;
            end
        end
        s1 = r.instr[25:21];
        s2 = r.instr[20:16];
        e.ctl = r.ctl;
        e.a = gp[s1];
        e.b = r.bimm ? r.imm : gp[s2];
        e.sd = gp[s2];
        e.fa = fp[s1];
        e.fb = fp[s2];
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk($sformatf("v%0d.ctl", idx), {14'h0, dut_ctl}, {14'h0, g.ctl});
        chk($sformatf("v%0d.opa", idx), OPERAND_A, g.a);
        chk($sformatf("v%0d.opb", idx), OPERAND_B, g.b);
        chk($sformatf("v%0d.sdata", idx), STORE_DATA, g.sd);
        chk($sformatf("v%0d.fopa", idx), F_OPERAND_A, g.fa);
        chk($sformatf("v%0d.fopb", idx), F_OPERAND_B, g.fb);
        @(posedge clk);
        if (reset) begin
            if (r.gw && r.dst != 5'd0) gp[r.dst] = r.busw;
            if (r.fw) fp[r.dst] = r.fbusw;
        end
    endtask

    localparam logic [3:0] Z = 4'd0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            gp[i] = 32'h0;
            fp[i] = 32'h0;
        end

        tbl.push_back(v(rt(5'd3,5'd3,5'd1,6'h20), 32'h0, 32'h0, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd1));
        tbl.push_back(v(32'h20010005, 32'h5, 32'h0, cw(F_NONE,4'd0,Z), 1'b1, 32'h5, 1'b1, 1'b0, 5'd1));
        tbl.push_back(v(it(6'h08,5'd0,5'd2,16'hFFFF), 32'h77, 32'h0, cw(F_NONE,4'd0,Z), 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd2));
        tbl.push_back(v(it(6'h0C,5'd1,5'd3,16'hFFFF), 32'hCAFE0000, 32'h0, cw(F_NONE,4'd2,Z), 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 5'd3));
        tbl.push_back(v(32'h00221820, 32'h11, 32'h0, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd3));
        tbl.push_back(v(it(6'h08,5'd1,5'd1,16'h0001), 32'h99, 32'h0, cw(F_NONE,4'd0,Z), 1'b1, 32'h1, 1'b1, 1'b0, 5'd1));
        tbl.push_back(v(it(6'h08,5'd0,5'd0,16'h0001), 32'hDEADBEEF, 32'h0, cw(F_NONE,4'd0,Z), 1'b1, 32'h1, 1'b1, 1'b0, 5'd0));
        tbl.push_back(v(rt(5'd0,5'd3,5'd5,6'h22), 32'h5, 32'h0, cw(F_NONE,4'd1,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd5));
        tbl.push_back(v(32'hAC220008, 32'hBAD0BAD0, 32'h0, cw(F_MW,4'd0,Z), 1'b1, 32'h8, 1'b0, 1'b0, 5'd2));
        tbl.push_back(v(it(6'h20,5'd1,5'd6,16'h0004), 32'hFFFFFF80, 32'h0, cw(F_M2R|F_B|F_SE,4'd0,Z), 1'b1, 32'h4, 1'b1, 1'b0, 5'd6));
        tbl.push_back(v(it(6'h21,5'd1,5'd7,16'hFFFE), 32'h8000, 32'h0, cw(F_M2R|F_H|F_SE,4'd0,Z), 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 5'd7));
        tbl.push_back(v(it(6'h25,5'd1,5'd7,16'h8000), 32'h1, 32'h0, cw(F_M2R|F_H,4'd0,Z), 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 5'd7));
        tbl.push_back(v(it(6'h24,5'd1,5'd8,16'h0000), 32'h2, 32'h0, cw(F_M2R|F_B,4'd0,Z), 1'b1, 32'h0, 1'b1, 1'b0, 5'd8));
        tbl.push_back(v(it(6'h23,5'd1,5'd8,16'h0000), 32'h3, 32'h0, cw(F_M2R,4'd0,Z), 1'b1, 32'h0, 1'b1, 1'b0, 5'd8));
        tbl.push_back(v(it(6'h28,5'd1,5'd2,16'h0003), 32'h0, 32'h0, cw(F_MW,4'd0,Z), 1'b1, 32'h3, 1'b0, 1'b0, 5'd2));
        tbl.push_back(v(32'h0C000010, 32'h108, 32'h0, cw(F_J|F_JAL,4'd0,Z), 1'b1, 32'h10, 1'b1, 1'b0, 5'd31));
        tbl.push_back(v(32'h4BE00000, 32'hAAAA, 32'h0, cw(F_J|F_JR,4'd0,Z), 1'b1, 32'h0, 1'b0, 1'b0, 5'd0));
        tbl.push_back(v(it(6'h13,5'd3,5'd0,16'h0000), 32'h200, 32'h0, cw(F_J|F_JR|F_JAL,4'd0,Z), 1'b1, 32'h0, 1'b1, 1'b0, 5'd31));
        tbl.push_back(v(it(6'h02,5'd0,5'd0,16'h0040), 32'h0, 32'h0, cw(F_J,4'd0,Z), 1'b1, 32'h40, 1'b0, 1'b0, 5'd0));
        tbl.push_back(v(it(6'h04,5'd1,5'd0,16'hFFFC), 32'h0, 32'h0, cw(F_BR,4'd8,Z), 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0));
        tbl.push_back(v(it(6'h05,5'd1,5'd0,16'h0008), 32'h0, 32'h0, cw(F_BR,4'd9,Z), 1'b1, 32'h8, 1'b0, 1'b0, 5'd0));
        tbl.push_back(v(it(6'h14,5'd1,5'd9,16'h8003), 32'h28, 32'h0, cw(F_NONE,4'd5,Z), 1'b1, 32'h00008003, 1'b1, 1'b0, 5'd9));
        tbl.push_back(v(it(6'h17,5'd1,5'd9,16'h001F), 32'h4, 32'h0, cw(F_NONE,4'd7,Z), 1'b1, 32'h1F, 1'b1, 1'b0, 5'd9));
        tbl.push_back(v(it(6'h0F,5'd0,5'd10,16'h1234), 32'h12340000, 32'h0, cw(F_NONE,4'd14,Z), 1'b1, 32'h1234, 1'b1, 1'b0, 5'd10));
        tbl.push_back(v(it(6'h1B,5'd1,5'd11,16'hFF00), 32'h1, 32'h0, cw(F_NONE,4'd11,Z), 1'b1, 32'hFFFFFF00, 1'b1, 1'b0, 5'd11));
        tbl.push_back(v(it(6'h0E,5'd1,5'd11,16'h8000), 32'h2, 32'h0, cw(F_NONE,4'd4,Z), 1'b1, 32'h00008000, 1'b1, 1'b0, 5'd11));
        tbl.push_back(v(it(6'h09,5'd1,5'd12,16'hFFFF), 32'h3, 32'h0, cw(F_NONE,4'd0,Z), 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 5'd12));
        tbl.push_back(v(it(6'h0B,5'd1,5'd12,16'hFFFF), 32'h4, 32'h0, cw(F_NONE,4'd1,Z), 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 5'd12));
        tbl.push_back(v(it(6'h0A,5'd1,5'd12,16'hFFFF), 32'h5, 32'h0, cw(F_NONE,4'd1,Z), 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd12));
        tbl.push_back(v(it(6'h0D,5'd1,5'd12,16'h8000), 32'h6, 32'h0, cw(F_NONE,4'd3,Z), 1'b1, 32'h00008000, 1'b1, 1'b0, 5'd12));
        tbl.push_back(v(it(6'h1D,5'd1,5'd12,16'h8000), 32'h7, 32'h0, cw(F_NONE,4'd13,Z), 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 5'd12));
        tbl.push_back(v(rt(5'd1,5'd2,5'd13,6'h07), 32'h8, 32'h0, cw(F_NONE,4'd7,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd13));
        tbl.push_back(v(rt(5'd1,5'd2,5'd13,6'h2C), 32'h9, 32'h0, cw(F_NONE,4'd12,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd13));
        tbl.push_back(v(rt(5'd4,5'd5,5'd13,6'h26), 32'hA, 32'h0, cw(F_NONE,4'd4,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd13));
        tbl.push_back(v(rt(5'd1,5'd2,5'd13,6'h2A), 32'hB, 32'h0, cw(F_NONE,4'd10,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd13));
        tbl.push_back(v(rt(5'd1,5'd0,5'd3,6'h35), 32'h0, 32'h3F800000, cw(F_MOV,4'd15,Z), 1'b0, 32'h0, 1'b0, 1'b1, 5'd3));
        tbl.push_back(v(ft(5'd3,5'd3,5'd4,6'h02), 32'h0, 32'h40000000, cw(F_NONE,4'd0,4'd4), 1'b0, 32'h0, 1'b0, 1'b1, 5'd4));
        tbl.push_back(v(ft(5'd3,5'd4,5'd0,6'h16), 32'h0, 32'h12345678, cw(F_NONE,4'd0,4'd1), 1'b0, 32'h0, 1'b0, 1'b1, 5'd0));
        tbl.push_back(v(ft(5'd0,5'd4,5'd5,6'h00), 32'h0, 32'h1, cw(F_NONE,4'd0,4'd2), 1'b0, 32'h0, 1'b0, 1'b1, 5'd5));
        tbl.push_back(v(ft(5'd5,5'd0,5'd6,6'h01), 32'h0, 32'h2, cw(F_NONE,4'd0,4'd3), 1'b0, 32'h0, 1'b0, 1'b1, 5'd6));
        tbl.push_back(v(ft(5'd5,5'd0,5'd6,6'h03), 32'h0, 32'h3, cw(F_NONE,4'd0,4'd5), 1'b0, 32'h0, 1'b0, 1'b1, 5'd6));
        tbl.push_back(v(ft(5'd6,5'd0,5'd6,6'h0E), 32'h0, 32'h4, cw(F_NONE,4'd0,4'd0), 1'b0, 32'h0, 1'b0, 1'b1, 5'd6));
        tbl.push_back(v(rt(5'd4,5'd0,5'd14,6'h34), 32'h40000000, 32'h0, cw(F_MOV,4'd15,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd14));
        tbl.push_back(v(32'h00000000, 32'hFFFF, 32'hFFFF, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b0, 1'b0, 5'd0));
        tbl.push_back(v(32'hFC000123, 32'h77777777, 32'h0, cw(F_NONE,4'd0,Z), 1'b1, 32'h123, 1'b0, 1'b0, 5'd0));
        tbl.push_back(v(ft(5'd1,5'd2,5'd7,6'h3F), 32'h0, 32'h55, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b0, 1'b0, 5'd7));
        tbl.push_back(v(rt(5'd14,5'd1,5'd15,6'h20), 32'h0, 32'h0, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd15));
        tbl.push_back(v(ft(5'd7,5'd6,5'd8,6'h00), 32'h0, 32'h0, cw(F_NONE,4'd0,4'd2), 1'b0, 32'h0, 1'b0, 1'b1, 5'd8));

        // Reset held: decode stays live, operands zero, no write at edge
        step(100, v(32'h00221820, 32'h0, 32'h0, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd3), 1'b0);
        step(101, v(it(6'h08,5'd0,5'd3,16'h0005), 32'h1111, 32'h2222, cw(F_NONE,4'd0,Z), 1'b1, 32'h5, 1'b1, 1'b0, 5'd3), 1'b0);

        foreach (tbl[i]) step(i, tbl[i], 1'b1);

        // Mid-run reset clears both files immediately
        step(200, v(rt(5'd14,5'd31,5'd1,6'h20), 32'h55, 32'h0, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b1, 1'b0, 5'd1), 1'b0);
        step(201, v(ft(5'd4,5'd3,5'd1,6'h00), 32'h0, 32'h66, cw(F_NONE,4'd0,4'd2), 1'b0, 32'h0, 1'b0, 1'b1, 5'd1), 1'b0);
        step(202, v(rt(5'd1,5'd14,5'd2,6'h20), 32'h0, 32'h0, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b0, 1'b0, 5'd2), 1'b1);
        step(203, v(it(6'h08,5'd0,5'd14,16'h0066), 32'h66, 32'h0, cw(F_NONE,4'd0,Z), 1'b1, 32'h66, 1'b1, 1'b0, 5'd14), 1'b1);
        step(204, v(rt(5'd14,5'd0,5'd2,6'h20), 32'h0, 32'h0, cw(F_NONE,4'd0,Z), 1'b0, 32'h0, 1'b0, 1'b0, 5'd2), 1'b1);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0",
                     sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
